// File: rtl/tlul_sram_resp.sv
// TL-UL device adapter for a single-port SRAM macro with 1-cycle read latency.
// The TL-UL channel types live in tlul_pkg, kept beside the adapter that consumes them.
package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [3:0] TL_D_USER_DEFAULT = 4'h0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_sram_resp
    import tlul_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned MemDepth = 1024,
    parameter int unsigned RspDepth = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  tl_h2d_t                     tl_i,
    output tl_d2h_t                     tl_o,
    output logic                        req_o,
    output logic                        we_o,
    output logic [$clog2(MemDepth)-1:0] addr_o,
    output logic [31:0]                 wdata_o,
    output logic [31:0]                 wmask_o,
    input  logic [31:0]                 rdata_i
);
    localparam int unsigned AW = $clog2(MemDepth);
    localparam int unsigned PW = $clog2(RspDepth);
    localparam int unsigned CW = $clog2(RspDepth + 1);
    localparam logic [32:0] MemBytes = 33'(MemDepth) * 33'd4;

    typedef struct packed {
        logic        get;
        logic        err;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
    } rsp_t;

    logic          a_ready, accept, is_get, is_put, a_err;
    logic          align_err, range_err, mask_err;
    logic [31:0]   offset;
    logic [3:0]    full_mask;

    logic          pend_valid, pend_get, pend_err;
    logic [1:0]    pend_size;
    logic [7:0]    pend_source;

    rsp_t          fifo_q [RspDepth];
    rsp_t          push_entry, head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          d_valid, pop;

    // Registered state only, so d_ready never reaches a_ready combinationally.
    assign a_ready = (32'(count) + 32'(pend_valid)) < RspDepth;
    assign accept  = tl_i.a_valid & a_ready;

    always_comb begin
        is_get = (tl_i.a_opcode == Get);
        is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        offset = tl_i.a_address - BaseAddr;
        range_err = (tl_i.a_address < BaseAddr) || ({1'b0, offset} >= MemBytes);
        align_err = 1'b0;
        full_mask = 4'hF;
        case (tl_i.a_size)
            2'd0: full_mask = 4'b0001 << tl_i.a_address[1:0];
            2'd1: begin
                align_err = tl_i.a_address[0];
                full_mask = 4'b0011 << tl_i.a_address[1:0];
            end
            default: align_err = (tl_i.a_address[1:0] != 2'b00);
        endcase
        mask_err = (tl_i.a_opcode == PutFullData) && (tl_i.a_mask != full_mask);
        a_err = !(is_get || is_put) || (tl_i.a_size == 2'd3) || align_err || range_err || mask_err;
    end

    always_comb begin
        req_o   = accept & !a_err;
        we_o    = req_o & is_put;
        addr_o  = req_o ? offset[AW+1:2] : '0;
        wdata_o = req_o ? tl_i.a_data : '0;
        wmask_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask_o[8*i +: 8] = {8{req_o & tl_i.a_mask[i]}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid  <= 1'b0;
            pend_get    <= 1'b0;
            pend_err    <= 1'b0;
            pend_size   <= '0;
            pend_source <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_get    <= is_get;
                pend_err    <= a_err;
                pend_size   <= tl_i.a_size;
                pend_source <= tl_i.a_source;
            end
        end
    end

    always_comb begin
        push_entry.get    = pend_get;
        push_entry.err    = pend_err;
        push_entry.size   = pend_size;
        push_entry.source = pend_source;
        push_entry.data   = pend_get ? (pend_err ? '1 : rdata_i) : '0;
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk_i) begin
        if (pend_valid) fifo_q[wptr] <= push_entry;
    end

    assign d_valid = (count != '0);
    assign pop     = d_valid & tl_i.d_ready;
    assign head    = fifo_q[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pend_valid) wptr <= (wptr == PW'(RspDepth - 1)) ? '0 : wptr + PW'(1);
            if (pop)        rptr <= (rptr == PW'(RspDepth - 1)) ? '0 : rptr + PW'(1);
            case ({pend_valid, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = head.get ? AccessAckData : AccessAck;
            tl_o.d_size   = head.size;
            tl_o.d_source = head.source;
            tl_o.d_data   = head.data;
            tl_o.d_user   = TL_D_USER_DEFAULT;
            tl_o.d_error  = head.err;
        end
    end
endmodule

// File: tb/tb_tlul_sram_resp.sv
// Scoreboard bench for tlul_sram_resp with a behavioural 1-cycle SRAM behind it.
module tb_tlul_sram_resp;
    import tlul_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RSP   = 3;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  src;
        logic [1:0]  size;
        logic        err;
        logic        body;
        logic        lat;
        int unsigned cyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    tl_h2d_t                  tl_i;
    tl_d2h_t                  tl_o;
    logic                     req_o, we_o;
    logic [$clog2(DEPTH)-1:0] addr_o;
    logic [31:0]              wdata_o, wmask_o, rdata;

    logic [31:0] sram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        sb [$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic        lat_on = 1'b0;

    tlul_sram_resp #(.BaseAddr(BASE), .MemDepth(DEPTH), .RspDepth(RSP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .wmask_o(wmask_o), .rdata_i(rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (req_o && we_o)  sram[addr_o] <= (sram[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
        if (req_o && !we_o) rdata <= sram[addr_o];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] bits_of(input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic push_expect(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] sz,
                               input logic [3:0] m, input logic [31:0] d, input logic [7:0] src,
                               input logic err);
        exp_t        e;
        int unsigned w;
        w      = (addr - BASE) >> 2;
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.src  = src;
        e.size = sz;
        e.err  = err;
        e.body = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
        e.lat  = lat_on;
        e.cyc  = cyc;
        if (err)              e.data = (op == 3'd4) ? 32'hFFFF_FFFF : 32'h0;
        else if (op == 3'd4)  e.data = ref_mem[w];
        else begin
            ref_mem[w] = (ref_mem[w] & ~bits_of(m)) | (d & bits_of(m));
            e.data     = 32'h0;
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] sz,
                        input logic [3:0] m, input logic [31:0] d, input logic [7:0] src,
                        input logic err, output logic stalled);
        logic        done;
        logic [31:0] w;
        done = 1'b0;
        stalled = 1'b0;
        w = (addr - BASE) >> 2;
        tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_size = sz;
        tl_i.a_mask = m; tl_i.a_data = d; tl_i.a_source = src;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                if (!err) begin
                    check("req_o", req_o, 1);
                    check("addr_o", addr_o, w[$clog2(DEPTH)-1:0]);
                    check("we_o", we_o, op != 3'd4);
                    if (op != 3'd4) begin
                        check("wmask_o", wmask_o, bits_of(m));
                        check("wdata_o", wdata_o, d);
                    end
                end else begin
                    check("req_o_on_error", req_o, 0);
                end
                push_expect(op, addr, sz, m, d, src, err);
                done = 1'b1;
            end else begin
                stalled = 1'b1;
            end
            @(posedge clk); #1;
        end
        tl_i.a_valid = 1'b0;
        if (!done) check("a_ready_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check(tag, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && tl_o.d_valid && tl_i.d_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("d_source", tl_o.d_source, mon_e.src);
                check("d_size", tl_o.d_size, mon_e.size);
                check("d_error", tl_o.d_error, mon_e.err);
                check("d_param_sink", {tl_o.d_param, tl_o.d_sink}, 0);
                if (mon_e.body) begin
                    check("d_opcode", tl_o.d_opcode, mon_e.op);
                    check("d_data", tl_o.d_data, mon_e.data);
                end
                if (mon_e.lat) check("latency", cyc - mon_e.cyc, 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic    st;
        int      acc;
        tl_d2h_t snap, head;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
            ref_mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
        end
        sram[32] = 32'hDEAD_BEEF; ref_mem[32] = 32'hDEAD_BEEF;
        sram[33] = 32'h1122_3344; ref_mem[33] = 32'h1122_3344;
        rdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap = tl_o;
        snap.a_ready = 1'b0;
        check("rst_d_fields", snap, 0);
        check("rst_a_ready", tl_o.a_ready, 1);
        check("rst_sram_if", {req_o, we_o, addr_o, wdata_o, wmask_o}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single Get, latency 2
        lat_on = 1'b1;
        send(3'd4, 32'h80, 2'd2, 4'hF, 32'h0, 8'd3, 1'b0, st);
        drain("single_get_drain");

        // Partial write, full write, read back
        send(3'd1, 32'h84, 2'd2, 4'b0010, 32'h0000_AB00, 8'd4, 1'b0, st);
        send(3'd4, 32'h84, 2'd2, 4'hF, 32'h0, 8'd5, 1'b0, st);
        send(3'd0, 32'h88, 2'd2, 4'hF, 32'hCAFE_F00D, 8'd6, 1'b0, st);
        send(3'd4, 32'h88, 2'd2, 4'hF, 32'h0, 8'd7, 1'b0, st);
        send(3'd0, 32'h8E, 2'd1, 4'b1100, 32'h7777_0000, 8'd8, 1'b0, st);
        send(3'd4, 32'h8D, 2'd0, 4'b0010, 32'h0, 8'd9, 1'b0, st);
        drain("write_read_drain");
        check("partial_merge", ref_mem[33], 32'h1122_AB44);

        // Error cases
        send(3'd4, BASE + 4 * DEPTH, 2'd2, 4'hF, 32'h0, 8'd10, 1'b1, st);
        send(3'd5, 32'h80, 2'd2, 4'hF, 32'h0, 8'd11, 1'b1, st);
        send(3'd4, 32'h82, 2'd2, 4'hF, 32'h0, 8'd12, 1'b1, st);
        send(3'd0, 32'h80, 2'd2, 4'b0111, 32'h1234_5678, 8'd13, 1'b1, st);
        send(3'd4, 32'h80, 2'd3, 4'hF, 32'h0, 8'd14, 1'b1, st);
        send(3'd4, BASE + 4 * DEPTH - 4, 2'd2, 4'hF, 32'h0, 8'd15, 1'b0, st);
        drain("error_drain");

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            send(3'd4, 32'h80 + 32'(4 * i), 2'd2, 4'hF, 32'h0, 8'(32 + i), 1'b0, st);
            check("stream_no_stall", st, 0);
        end
        drain("stream_drain");

        // Backpressure
        lat_on = 1'b0;
        tl_i.d_ready = 1'b0;
        acc = 0;
        tl_i.a_valid = 1'b1; tl_i.a_opcode = 3'd4; tl_i.a_size = 2'd2; tl_i.a_mask = 4'hF;
        tl_i.a_address = 32'h90; tl_i.a_source = 8'd64;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            st = tl_o.a_ready;
            if (st) begin
                push_expect(3'd4, tl_i.a_address, 2'd2, 4'hF, 32'h0, tl_i.a_source, 1'b0);
                acc++;
            end
            @(posedge clk); #1;
            if (st) begin
                tl_i.a_address = tl_i.a_address + 32'd4;
                tl_i.a_source  = tl_i.a_source + 8'd1;
            end
        end
        check("bp_accepted", acc, RSP);
        @(negedge clk);
        check("bp_a_ready_low", tl_o.a_ready, 0);
        head = tl_o;
        repeat (3) @(negedge clk);
        check("bp_head_stable", tl_o, head);
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        drain("bp_drain");

        // Reset with two responses queued
        tl_i.d_ready = 1'b0;
        send(3'd4, 32'h90, 2'd2, 4'hF, 32'h0, 8'd80, 1'b0, st);
        send(3'd4, 32'h94, 2'd2, 4'hF, 32'h0, 8'd81, 1'b0, st);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_d_valid", tl_o.d_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_d_valid", tl_o.d_valid, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_a_ready", tl_o.a_ready, 1);
        @(posedge clk); #1;
        tl_i.d_ready = 1'b1;
        lat_on = 1'b1;
        send(3'd4, 32'h80, 2'd2, 4'hF, 32'h0, 8'd90, 1'b0, st);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
